// File: rtl/speed_chk_pkg.sv
// rtl/speed_chk_pkg.sv - shared state encoding and default constants for speed_window_checker
//
// Purpose : FSM state type, state constants and the default values of the
//           checker's width/window parameters. Imported by speed_window_checker.
// Ports   : none (package).
package speed_chk_pkg;

  localparam int CNT_W_DEF  = 9;   // per-channel pulse counter width
  localparam int WINDOW_DEF = 10;  // seconds per measurement run
  localparam int PASS_W_DEF = 5;   // pass counter width, 2**PASS_W > WINDOW

  // Second counter is sized for the largest legal WINDOW (31).
  localparam int SEC_W = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/pulse_sync_edge.sv
// rtl/pulse_sync_edge.sv - two-flop synchroniser plus rising-edge detector
//
// Purpose : Brings one asynchronous sensor pulse into the clk domain and
//           flags each rising edge for exactly one cycle.
// Ports   : clk_i   - system clock
//           reset_i - synchronous active-high reset, clears all flops
//           pulse_i - raw asynchronous pulse
//           edge_o  - one-cycle rising-edge flag; a pin edge sampled on
//                     clock n is visible between clocks n+1 and n+2
module pulse_sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pulse_i,
  output logic edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= pulse_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Combinational so the owning counter updates on the third clock after the pin.
  assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/speed_window_checker.sv
// rtl/speed_window_checker.sv - multi-channel pulses-per-second window checker
//
// Purpose : After a start strobe, counts synchronised pulse edges per channel
//           for WINDOW seconds (sec_tick strobes) and counts, per channel, how
//           many seconds reached the threshold latched at start.
// Option  : define SPEED_CHK_PEAK_EN to add peak_count, the per-channel maximum
//           per-second pulse count within the run.
// Ports   : clk        - system clock, rising edge
//           reset      - synchronous active-high reset
//           start      - one-cycle strobe, begins a run (accepted in IDLE only)
//           sec_tick   - one-cycle strobe per second boundary
//           pulse_in   - asynchronous sensor pulses, one bit per channel
//           thresh     - minimum pulses per second for a pass, latched at start
//           pass_count - passing seconds, channel i at [i*PASS_W +: PASS_W]
//           busy       - high while a run is in progress
//           done       - one-cycle strobe when a run completes
//           peak_count - (SPEED_CHK_PEAK_EN) channel i at [i*CNT_W +: CNT_W]
module speed_window_checker
  import speed_chk_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WINDOW   = WINDOW_DEF,
  parameter int PASS_W   = PASS_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       sec_tick,
  input  logic [CHANNELS-1:0]        pulse_in,
  input  logic [CNT_W-1:0]           thresh,
  output logic [CHANNELS*PASS_W-1:0] pass_count,
  output logic                       busy,
  output logic                       done
`ifdef SPEED_CHK_PEAK_EN
  ,
  output logic [CHANNELS*CNT_W-1:0]  peak_count
`endif
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [PASS_W-1:0] PASS_MAX = PASS_W'(WINDOW);
  localparam logic [SEC_W-1:0]  SEC_LAST = SEC_W'(WINDOW - 1);

  state_t            state_q, state_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [CNT_W-1:0]  thr_q, thr_d;
  logic [CNT_W-1:0]  cnt_q  [CHANNELS];
  logic [CNT_W-1:0]  cnt_d  [CHANNELS];
  logic [PASS_W-1:0] pass_q [CHANNELS];
  logic [PASS_W-1:0] pass_d [CHANNELS];
  logic [CHANNELS-1:0] edge_w;

  // Count including this cycle's edge, so an edge coinciding with sec_tick
  // is credited to the second that is closing.
  logic [CNT_W-1:0]  cnt_inc [CHANNELS];

`ifdef SPEED_CHK_PEAK_EN
  logic [CNT_W-1:0]  peak_q [CHANNELS];
  logic [CNT_W-1:0]  peak_d [CHANNELS];
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pulse_sync_edge u_sync (
      .clk_i   (clk),
      .reset_i (reset),
      .pulse_i (pulse_in[g]),
      .edge_o  (edge_w[g])
    );
    assign pass_count[g*PASS_W +: PASS_W] = pass_q[g];
`ifdef SPEED_CHK_PEAK_EN
    assign peak_count[g*CNT_W +: CNT_W] = peak_q[g];
`endif
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_inc[i] = (edge_w[i] && (cnt_q[i] != CNT_MAX)) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    thr_d   = thr_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]  = cnt_q[i];
      pass_d[i] = pass_q[i];
`ifdef SPEED_CHK_PEAK_EN
      peak_d[i] = peak_q[i];
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          sec_d   = '0;
          thr_d   = thresh;
          for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]  = '0;
            pass_d[i] = '0;
`ifdef SPEED_CHK_PEAK_EN
            peak_d[i] = '0;
`endif
          end
        end
      end

      ST_RUN: begin
        for (int i = 0; i < CHANNELS; i++) begin
          cnt_d[i] = cnt_inc[i];
        end
        if (sec_tick) begin
          for (int i = 0; i < CHANNELS; i++) begin
            // A zero threshold passes every second since any count is >= 0.
            if ((cnt_inc[i] >= thr_q) && (pass_q[i] != PASS_MAX)) begin
              pass_d[i] = pass_q[i] + PASS_W'(1);
            end
`ifdef SPEED_CHK_PEAK_EN
            if (cnt_inc[i] > peak_q[i]) begin
              peak_d[i] = cnt_inc[i];
            end
`endif
            cnt_d[i] = '0;
          end
          sec_d = sec_q + SEC_W'(1);
          if (sec_q == SEC_LAST) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sec_q   <= '0;
      thr_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        pass_q[i] <= '0;
`ifdef SPEED_CHK_PEAK_EN
        peak_q[i] <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      thr_q   <= thr_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        pass_q[i] <= pass_d[i];
`ifdef SPEED_CHK_PEAK_EN
        peak_q[i] <= peak_d[i];
`endif
      end
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_speed_window_checker.sv
// tb/tb_speed_window_checker.sv - self-checking bench for speed_window_checker
module tb_speed_window_checker;

  localparam int CH      = 2;
  localparam int CNT_W   = 9;
  localparam int WINDOW  = 10;
  localparam int PASS_W  = 5;
  localparam int CMAX    = 511;
  localparam int SEC_LEN = 120;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     start = 1'b0;
  logic                     sec_tick = 1'b0;
  logic [CH-1:0]            pulse_in = '0;
  logic [CNT_W-1:0]         thresh = '0;
  logic [CH*PASS_W-1:0]     pass_count;
  logic                     busy;
  logic                     done;
`ifdef SPEED_CHK_PEAK_EN
  logic [CH*CNT_W-1:0]      peak_count;
`endif

  speed_window_checker #(
    .CHANNELS (CH),
    .CNT_W    (CNT_W),
    .WINDOW   (WINDOW),
    .PASS_W   (PASS_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sec_tick   (sec_tick),
    .pulse_in   (pulse_in),
    .thresh     (thresh),
    .pass_count (pass_count),
    .busy       (busy),
    .done       (done)
`ifdef SPEED_CHK_PEAK_EN
    ,
    .peak_count (peak_count)
`endif
  );

  always #5 clk = ~clk;

  int  n_chk = 0;
  int  n_pass = 0;
  int  done_seen = 0;
  bit  chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a pin rise sampled on clock n is counted on clock n+2.
  int cyc = 0;
  int m_state = 0;   // 0 idle, 1 running, 2 finished
  int m_sec = 0;
  int m_thr = 0;
  int m_cnt  [CH] = '{default: 0};
  int m_pass [CH] = '{default: 0};
  int m_peak [CH] = '{default: 0};
  int m_prev [CH] = '{default: 0};
  int m_edge [CH] = '{default: 0};
  int due_q  [CH][$];

  task automatic model_step();
    if (reset) begin
      m_state = 0;
      m_sec   = 0;
      m_thr   = 0;
      for (int c = 0; c < CH; c++) begin
        m_cnt[c] = 0; m_pass[c] = 0; m_peak[c] = 0; m_prev[c] = 0;
        due_q[c].delete();
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        m_edge[c] = 0;
        if (due_q[c].size() > 0 && due_q[c][0] == cyc) begin
          m_edge[c] = 1;
          void'(due_q[c].pop_front());
        end
        if (pulse_in[c] && m_prev[c] == 0) due_q[c].push_back(cyc + 2);
        m_prev[c] = int'(pulse_in[c]);
      end
      case (m_state)
        0: if (start) begin
          m_state = 1;
          m_sec   = 0;
          m_thr   = int'(thresh);
          for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; m_pass[c] = 0; m_peak[c] = 0;
          end
        end
        1: begin
          for (int c = 0; c < CH; c++)
            m_cnt[c] = (m_cnt[c] + m_edge[c] > CMAX) ? CMAX : m_cnt[c] + m_edge[c];
          if (sec_tick) begin
            for (int c = 0; c < CH; c++) begin
              if (m_cnt[c] >= m_thr && m_pass[c] < WINDOW) m_pass[c]++;
              if (m_cnt[c] > m_peak[c]) m_peak[c] = m_cnt[c];
              m_cnt[c] = 0;
            end
            m_sec++;
            if (m_sec == WINDOW) m_state = 2;
          end
        end
        default: m_state = 0;
      endcase
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_state == 1));
      chk("done", int'(done), int'(m_state == 2));
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("pass_count_ch%0d", c), int'(pass_count[c*PASS_W +: PASS_W]), m_pass[c]);
`ifdef SPEED_CHK_PEAK_EN
        chk($sformatf("peak_count_ch%0d", c), int'(peak_count[c*CNT_W +: CNT_W]), m_peak[c]);
`endif
      end
      if (done) done_seen++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic [CH-1:0] p, input logic t, input logic s);
    pulse_in = p;
    sec_tick = t;
    start    = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0);
  endtask

  task automatic do_start(input int thr);
    thresh = CNT_W'(thr);
    drive('0, 1'b0, 1'b1);
  endtask

  // n0/n1 pulses on even cycles from the start of the second; optional
  // ignored start strobe plus threshold change at cycle start_at.
  task automatic sec_pattern(input int n0, input int n1, input int len, input int start_at);
    logic [CH-1:0] p;
    for (int j = 0; j < len; j++) begin
      p[0] = (j % 2 == 0) && (j / 2 < n0);
      p[1] = (j % 2 == 0) && (j / 2 < n1);
      if (j == start_at) thresh = '0;
      drive(p, j == len - 1, j == start_at);
    end
  endtask

  // ch0: 32 early pulses plus one more whose rise is sampled at cycle last_at.
  task automatic sec_late(input int last_at, input int len);
    logic [CH-1:0] p;
    for (int j = 0; j < len; j++) begin
      p    = '0;
      p[0] = ((j % 2 == 0) && (j < 64)) || (j == last_at);
      drive(p, j == len - 1, 1'b0);
    end
  endtask

  task automatic rand_second(input int len);
    logic [CH-1:0] p;
    logic          s;
    for (int j = 0; j < len; j++) begin
      for (int c = 0; c < CH; c++) p[c] = ($urandom_range(0, 2) == 0);
      s = (j != len - 1) && ($urandom_range(0, 63) == 0);
      if (s) thresh = CNT_W'($urandom_range(0, 40));
      drive(p, j == len - 1, s);
    end
  endtask

  initial begin
    // Reset state
    idle(3);
    chk_en = 1'b1;
    reset  = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_pass", int'(pass_count), 0);
    idle(2);

    // 40 vs 20 pulses/s against threshold 33
    done_seen = 0;
    do_start(33);
    for (int s = 0; s < WINDOW; s++) sec_pattern(40, 20, SEC_LEN, -1);
    idle(4);
    chk("s1_pass_ch0", int'(pass_count[4:0]), 10);
    chk("s1_pass_ch1", int'(pass_count[9:5]), 0);
    chk("s1_done_count", done_seen, 1);

    // 33 pulses for five seconds then 32
    do_start(33);
    for (int s = 0; s < WINDOW; s++) sec_pattern((s < 5) ? 33 : 32, 33, SEC_LEN, -1);
    idle(4);
    chk("s2_pass_ch0", int'(pass_count[4:0]), 5);
    chk("s2_pass_ch1", int'(pass_count[9:5]), 10);

    // Reset in the middle of a run
    done_seen = 0;
    do_start(33);
    for (int s = 0; s < 4; s++) sec_pattern(40, 40, SEC_LEN, -1);
    reset = 1'b1;
    drive('0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("s3_busy_after_reset", int'(busy), 0);
    chk("s3_pass_after_reset", int'(pass_count), 0);
    idle(30);
    chk("s3_no_done", done_seen, 0);

    // 33rd edge lands on the tick cycle; next second's 33rd edge is one cycle late
    do_start(33);
    sec_late(SEC_LEN - 3, SEC_LEN);
    sec_late(SEC_LEN - 2, SEC_LEN);
    for (int s = 2; s < WINDOW; s++) sec_pattern(0, 0, SEC_LEN, -1);
    idle(4);
    chk("s4_pass_ch0", int'(pass_count[4:0]), 1);

    // Start strobe and threshold change mid-run are ignored
    done_seen = 0;
    do_start(33);
    for (int s = 0; s < WINDOW - 1; s++) sec_pattern(33, 20, SEC_LEN, (s == 2) ? 40 : -1);
    chk("s5_busy_before_last", int'(busy), 1);
    sec_pattern(33, 20, SEC_LEN, -1);
    chk("s5_done_at_last_tick", int'(done), 1);
    idle(4);
    chk("s5_pass_ch0", int'(pass_count[4:0]), 10);
    chk("s5_pass_ch1", int'(pass_count[9:5]), 0);
    chk("s5_done_count", done_seen, 1);

    // Zero threshold passes every second, even with no pulses
    do_start(0);
    for (int s = 0; s < WINDOW; s++) sec_pattern(0, 0, 30, -1);
    idle(4);
    chk("s6_pass_all", int'(pass_count), 10 | (10 << PASS_W));

`ifdef SPEED_CHK_PEAK_EN
    // Peak of per-second counts 12, 50, 7
    do_start(5);
    sec_pattern(12, 3, SEC_LEN, -1);
    sec_pattern(50, 4, SEC_LEN, -1);
    sec_pattern(7, 5, SEC_LEN, -1);
    chk("s7_peak_ch0", int'(peak_count[8:0]), 50);
    chk("s7_peak_ch1", int'(peak_count[17:9]), 5);
    for (int s = 3; s < WINDOW; s++) sec_pattern(0, 0, 30, -1);
    idle(4);
    chk("s7_peak_held", int'(peak_count[8:0]), 50);
`endif

    // Random pulse trains, second lengths and thresholds
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(90, 140);
      do_start($urandom_range(15, 35));
      for (int s = 0; s < WINDOW; s++) rand_second(len);
      idle(4);
      chk("rand_idle_after_run", int'(busy), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
